// File: rtl/fg_config_loader.sv
// Assembles a framed, MSB-first byte stream into a shadow word and commits it
// to the function generator's configuration bus on its sample strobe.
module fg_config_loader #(
    parameter int CONFIG_REG_BITWIDTH = 56,
    parameter int TIMEOUT_BITWIDTH    = 8,
    parameter int TIMEOUT_CYCLES      = 200
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic [7:0]                     data_i,
    input  logic                           dataValid_i,
    input  logic                           sof_i,
    output logic                           ready_o,
    input  logic                           sync_i,
    input  logic                           genEnable_i,
    output logic [CONFIG_REG_BITWIDTH-1:0] CR_bus_o,
    output logic                           commit_STRB_o,
    output logic                           frameErr_o,
    output logic                           busy_o
);
    localparam int W         = CONFIG_REG_BITWIDTH;
    localparam int NUM_BYTES = W / 8;
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0]            LAST_CNT = CNT_W'(NUM_BYTES - 1);
    localparam logic [TIMEOUT_BITWIDTH-1:0] TMO_LAST = TIMEOUT_BITWIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_PENDING
    } state_t;

    state_t                      state_q, state_d;
    logic [W-1:0]                shadow_q, shadow_d;
    logic [W-1:0]                cr_q, cr_d;
    logic [W-1:0]                shifted;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [TIMEOUT_BITWIDTH-1:0] tmo_q, tmo_d;
    logic                        commit_q, commit_d;
    logic                        err_q, err_d;
    logic                        accept;

    assign ready_o = (state_q != S_PENDING);
    assign busy_o  = (state_q != S_IDLE);
    assign accept  = dataValid_i && ready_o;

    // A single-byte word has nothing to shift; the byte is the whole word.
    generate
        if (NUM_BYTES == 1) begin : g_single
            assign shifted = data_i;
        end else begin : g_multi
            assign shifted = {shadow_q[W-9:0], data_i};
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cr_d     = cr_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        commit_d = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (sof_i) begin
                        shadow_d = shifted;
                        tmo_d    = '0;
                        if (NUM_BYTES == 1) begin
                            state_d = S_PENDING;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_RECV;
                            cnt_d   = CNT_W'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RECV: begin
                if (accept) begin
                    shadow_d = shifted;
                    tmo_d    = '0;
                    if (sof_i) begin
                        // A new SOF aborts the current frame and starts over.
                        err_d = 1'b1;
                        if (NUM_BYTES == 1) begin
                            state_d = S_PENDING;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = CNT_W'(1);
                        end
                    end else if (cnt_q == LAST_CNT) begin
                        state_d = S_PENDING;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d    = 1'b1;
                    state_d  = S_IDLE;
                    shadow_d = '0;
                    cnt_d    = '0;
                    tmo_d    = '0;
                end else begin
                    tmo_d = tmo_q + TIMEOUT_BITWIDTH'(1);
                end
            end
            S_PENDING: begin
                if (sync_i || !genEnable_i) begin
                    cr_d     = shadow_q;
                    commit_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            cr_q     <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            commit_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            cr_q     <= cr_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            commit_q <= commit_d;
            err_q    <= err_d;
        end
    end

    assign CR_bus_o      = cr_q;
    assign commit_STRB_o = commit_q;
    assign frameErr_o    = err_q;

endmodule

// File: tb/tb_fg_config_loader.sv
// Directed and randomized checks of fg_config_loader against a word-level model
// that packs each frame's bytes arithmetically and predicts pulse timing.
module tb_fg_config_loader;
    localparam int W  = 56;
    localparam int NB = W / 8;

    logic         clk_i = 1'b0;
    logic         rstn_i;
    logic [7:0]   data_i;
    logic         dataValid_i;
    logic         sof_i;
    logic         ready_o;
    logic         sync_i;
    logic         genEnable_i;
    logic [W-1:0] CR_bus_o;
    logic         commit_STRB_o;
    logic         frameErr_o;
    logic         busy_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] model_cr;
    logic [7:0]   frame [NB];

    always #5 clk_i = ~clk_i;

    fg_config_loader #(
        .CONFIG_REG_BITWIDTH(W),
        .TIMEOUT_BITWIDTH   (8),
        .TIMEOUT_CYCLES     (200)
    ) dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .data_i       (data_i),
        .dataValid_i  (dataValid_i),
        .sof_i        (sof_i),
        .ready_o      (ready_o),
        .sync_i       (sync_i),
        .genEnable_i  (genEnable_i),
        .CR_bus_o     (CR_bus_o),
        .commit_STRB_o(commit_STRB_o),
        .frameErr_o   (frameErr_o),
        .busy_o       (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // The committed word is the frame read as a big-endian base-256 number.
    function automatic logic [W-1:0] pack(input logic [7:0] b [NB]);
        logic [W-1:0] acc = '0;
        for (int i = 0; i < NB; i++) acc = acc * 256 + W'(b[i]);
        return acc;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic sof);
        data_i      = b;
        sof_i       = sof;
        dataValid_i = 1'b1;
        tick();
        dataValid_i = 1'b0;
        sof_i       = 1'b0;
    endtask

    task automatic rand_frame();
        for (int i = 0; i < NB; i++) frame[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        rstn_i = 1'b0; data_i = '0; dataValid_i = 0; sof_i = 0; sync_i = 0; genEnable_i = 0;
        model_cr = '0;
        #12;
        chk("reset_cr", 64'(CR_bus_o), 64'(model_cr));
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_ready", 64'(ready_o), 64'd1);
        chk("reset_strb", 64'(commit_STRB_o), 64'd0);
        chk("reset_err", 64'(frameErr_o), 64'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        tick();

        // Basic commit with the generator disabled
        frame = '{8'h81, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        for (int i = 0; i < NB; i++) send(frame[i], i == 0);
        chk("t1_ready_pending", 64'(ready_o), 64'd0);
        chk("t1_cr_before", 64'(CR_bus_o), 64'(model_cr));
        tick();
        model_cr = pack(frame);
        chk("t1_cr_value", 64'(CR_bus_o), 64'h0081_1234_5678_9ABC);
        chk("t1_strb", 64'(commit_STRB_o), 64'd1);
        chk("t1_ready_back", 64'(ready_o), 64'd1);
        tick();
        chk("t1_strb_low", 64'(commit_STRB_o), 64'd0);

        // Sync-gated commit; sync during the last byte must not commit
        genEnable_i = 1'b1;
        rand_frame();
        for (int i = 0; i < NB - 1; i++) send(frame[i], i == 0);
        sync_i = 1'b1;
        send(frame[NB-1], 1'b0);
        sync_i = 1'b0;
        chk("t2_no_early_strb", 64'(commit_STRB_o), 64'd0);
        for (int i = 0; i < 10; i++) begin
            chk("t2_wait_ready", 64'(ready_o), 64'd0);
            chk("t2_wait_cr", 64'(CR_bus_o), 64'(model_cr));
            tick();
        end
        sync_i = 1'b1;
        tick();
        sync_i = 1'b0;
        model_cr = pack(frame);
        chk("t2_cr", 64'(CR_bus_o), 64'(model_cr));
        chk("t2_strb", 64'(commit_STRB_o), 64'd1);
        tick();

        // Missing SOF, then a re-SOF that restarts the frame
        genEnable_i = 1'b0;
        send(8'h55, 1'b0);
        chk("t3_err_nosof", 64'(frameErr_o), 64'd1);
        chk("t3_idle", 64'(busy_o), 64'd0);
        send(8'h11, 1'b1);
        chk("t3_err_clear", 64'(frameErr_o), 64'd0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        rand_frame();
        frame[0] = 8'h81;
        send(frame[0], 1'b1);
        chk("t3_err_resof", 64'(frameErr_o), 64'd1);
        for (int i = 1; i < NB; i++) send(frame[i], 1'b0);
        tick();
        model_cr = pack(frame);
        chk("t3_cr", 64'(CR_bus_o), 64'(model_cr));
        chk("t3_strb", 64'(commit_STRB_o), 64'd1);
        tick();

        // Timeout after 200 idle cycles
        for (int i = 0; i < 4; i++) send(8'($urandom_range(0, 255)), i == 0);
        for (int k = 1; k < 200; k++) begin
            tick();
            if (k == 1 || k == 199) begin
                chk("t4_no_err_yet", 64'(frameErr_o), 64'd0);
                chk("t4_still_busy", 64'(busy_o), 64'd1);
            end
        end
        tick();
        chk("t4_timeout_err", 64'(frameErr_o), 64'd1);
        chk("t4_timeout_idle", 64'(busy_o), 64'd0);
        chk("t4_cr_kept", 64'(CR_bus_o), 64'(model_cr));
        tick();
        chk("t4_err_one_cycle", 64'(frameErr_o), 64'd0);

        // A byte in the expiry cycle continues the frame
        rand_frame();
        for (int i = 0; i < 4; i++) send(frame[i], i == 0);
        repeat (199) tick();
        send(frame[4], 1'b0);
        chk("t4b_no_err", 64'(frameErr_o), 64'd0);
        chk("t4b_busy", 64'(busy_o), 64'd1);
        send(frame[5], 1'b0);
        send(frame[6], 1'b0);
        tick();
        model_cr = pack(frame);
        chk("t4b_cr", 64'(CR_bus_o), 64'(model_cr));
        chk("t4b_strb", 64'(commit_STRB_o), 64'd1);
        tick();

        // Asynchronous reset mid-frame
        for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)), i == 0);
        #3 rstn_i = 1'b0;
        #1;
        model_cr = '0;
        chk("t5_cr_cleared", 64'(CR_bus_o), 64'(model_cr));
        chk("t5_busy", 64'(busy_o), 64'd0);
        chk("t5_ready", 64'(ready_o), 64'd1);
        @(negedge clk_i);
        rstn_i = 1'b1;
        tick();
        rand_frame();
        for (int i = 0; i < NB; i++) send(frame[i], i == 0);
        tick();
        model_cr = pack(frame);
        chk("t5_cr_after", 64'(CR_bus_o), 64'(model_cr));
        tick();

        // Randomized frames with gaps and random commit conditions
        for (int f = 0; f < 16; f++) begin
            logic gen;
            gen = 1'($urandom_range(0, 1));
            genEnable_i = gen;
            rand_frame();
            for (int i = 0; i < NB; i++) begin
                if (i > 0) repeat ($urandom_range(0, 5)) tick();
                send(frame[i], i == 0);
            end
            chk("rnd_pending", 64'(ready_o), 64'd0);
            if (gen) begin
                repeat ($urandom_range(0, 8)) begin
                    tick();
                    chk("rnd_hold_cr", 64'(CR_bus_o), 64'(model_cr));
                end
                sync_i = 1'b1;
                tick();
                sync_i = 1'b0;
            end else begin
                tick();
            end
            model_cr = pack(frame);
            chk("rnd_cr", 64'(CR_bus_o), 64'(model_cr));
            chk("rnd_strb", 64'(commit_STRB_o), 64'd1);
            chk("rnd_err", 64'(frameErr_o), 64'd0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
